// File: rtl/cnn_requant_writer.sv
// Requantizes signed 32-bit accumulators to int8, packs four per word and
// writes the packed words over a single-beat Wishbone master port.
module cnn_requant_writer #(
    parameter int ADDR_W = 30,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base_adr,
    input  logic [31:0]       cfg_bias,
    input  logic [31:0]       cfg_mult,
    input  logic [4:0]        cfg_shift,
    input  logic [8:0]        cfg_out_offset,
    input  logic              acc_valid,
    output logic              acc_ready,
    input  logic [31:0]       acc_data,
    input  logic              acc_last,
    output logic [ADDR_W-1:0] cfu_ram_adr,
    output logic [31:0]       cfu_ram_dat_mosi,
    output logic [3:0]        cfu_ram_sel,
    output logic              cfu_ram_cyc,
    output logic              cfu_ram_stb,
    output logic              cfu_ram_we,
    output logic [2:0]        cfu_ram_cti,
    output logic [1:0]        cfu_ram_bte,
    input  logic [31:0]       cfu_ram_dat_miso,
    input  logic              cfu_ram_ack,
    input  logic              cfu_ram_err,
    output logic              busy,
    output logic              done,
    output logic              err_flag,
    output logic [CNT_W-1:0]  words_written
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Q31 multiply with round-half-up, optional rounding shift, offset, int8 saturation.
    function automatic logic [7:0] requant(input logic [31:0] s1, input logic [31:0] mult,
                                           input logic [4:0] shift, input logic [8:0] offset);
        logic signed [63:0] prod;
        logic signed [63:0] prod_rnd;
        logic signed [31:0] h;
        logic signed [31:0] t;
        logic signed [31:0] r;
        logic signed [32:0] o;
        prod     = $signed({{32{s1[31]}}, s1}) * $signed({{32{mult[31]}}, mult});
        prod_rnd = prod + 64'sd1073741824;
        h        = prod_rnd[62:31];
        if (shift != 5'd0) begin
            t = h + (32'sd1 <<< (shift - 5'd1));
            r = t >>> shift;
        end else begin
            t = h;
            r = h;
        end
        o = {r[31], r} + {{24{offset[8]}}, offset};
        if (o > 33'sd127) begin
            requant = 8'h7F;
        end else if (o < -33'sd128) begin
            requant = 8'h80;
        end else begin
            requant = o[7:0];
        end
    endfunction

    state_t              state_r, state_next_s;
    logic                busy_r, done_r, err_flag_r, last_accepted_r, cyc_r;
    logic [CNT_W-1:0]    words_r;
    logic [ADDR_W-1:0]   ptr_r;
    logic                s1_valid_r, s1_last_r, s2_valid_r, s2_last_r;
    logic [31:0]         s1_data_r;
    logic [7:0]          s2_byte_r;
    logic [1:0]          idx_r;
    logic [31:0]         pack_data_r, merged_data_s, wbuf_data_r;
    logic [3:0]          pack_sel_r, merged_sel_s, wbuf_sel_r;
    logic                wbuf_full_r, wbuf_last_r;
    logic                start_s, acc_fire_s, completes_s, stall_s, wbuf_load_s, retire_s;
    logic                unused_miso_s;

    assign unused_miso_s = ^cfu_ram_dat_miso;
    assign start_s       = start & ~busy_r;
    assign acc_ready     = busy_r & ~wbuf_full_r & ~last_accepted_r;
    assign acc_fire_s    = acc_valid & acc_ready;
    assign completes_s   = s2_valid_r & ((idx_r == 2'd3) | s2_last_r);
    assign stall_s       = wbuf_full_r & completes_s;
    assign wbuf_load_s   = completes_s & ~wbuf_full_r;
    assign retire_s      = (state_r == ST_WAIT) & (cfu_ram_ack | cfu_ram_err);

    // Merge the stage-2 byte into the partially filled word at the current lane.
    always_comb begin
        merged_data_s = pack_data_r;
        merged_sel_s  = pack_sel_r;
        case (idx_r)
            2'd0:    begin merged_data_s[7:0]   = s2_byte_r; merged_sel_s[0] = 1'b1; end
            2'd1:    begin merged_data_s[15:8]  = s2_byte_r; merged_sel_s[1] = 1'b1; end
            2'd2:    begin merged_data_s[23:16] = s2_byte_r; merged_sel_s[2] = 1'b1; end
            2'd3:    begin merged_data_s[31:24] = s2_byte_r; merged_sel_s[3] = 1'b1; end
            default: begin merged_data_s = pack_data_r; merged_sel_s = pack_sel_r; end
        endcase
    end

    // Write FSM next state; the bus request is raised on the edge the buffer loads.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wbuf_full_r | wbuf_load_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (retire_s) begin
                    if (wbuf_last_r) begin
                        state_next_s = ST_FINISH;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_FINISH: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM state and registered bus/done strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cyc_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cyc_r   <= (state_next_s == ST_WAIT);
            done_r  <= (state_next_s == ST_FINISH);
        end
    end

    // Job control: pointer, retire counter, sticky error and busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r          <= 1'b0;
            ptr_r           <= '0;
            words_r         <= '0;
            err_flag_r      <= 1'b0;
            last_accepted_r <= 1'b0;
        end else if (start_s) begin
            busy_r          <= 1'b1;
            ptr_r           <= cfg_base_adr;
            words_r         <= '0;
            err_flag_r      <= 1'b0;
            last_accepted_r <= 1'b0;
        end else begin
            if (state_r == ST_FINISH) begin
                busy_r <= 1'b0;
            end
            if (acc_fire_s && acc_last) begin
                last_accepted_r <= 1'b1;
            end
            if (retire_s) begin
                ptr_r   <= ptr_r + ADDR_W'(1);
                words_r <= words_r + CNT_W'(1);
                if (cfu_ram_err) begin
                    err_flag_r <= 1'b1;
                end
            end
        end
    end

    // Two-stage arithmetic pipeline; holds while a completing word waits on the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_data_r  <= 32'd0;
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            s2_byte_r  <= 8'd0;
        end else if (!stall_s) begin
            s1_valid_r <= acc_fire_s;
            if (acc_fire_s) begin
                s1_data_r <= acc_data + cfg_bias;
                s1_last_r <= acc_last;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_byte_r <= requant(s1_data_r, cfg_mult, cfg_shift, cfg_out_offset);
                s2_last_r <= s1_last_r;
            end
        end
    end

    // Lane packer and one-entry write buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r       <= 2'd0;
            pack_data_r <= 32'd0;
            pack_sel_r  <= 4'd0;
            wbuf_full_r <= 1'b0;
            wbuf_last_r <= 1'b0;
            wbuf_data_r <= 32'd0;
            wbuf_sel_r  <= 4'd0;
        end else if (start_s) begin
            idx_r       <= 2'd0;
            pack_data_r <= 32'd0;
            pack_sel_r  <= 4'd0;
        end else begin
            if (s2_valid_r && !stall_s) begin
                if (completes_s) begin
                    idx_r       <= 2'd0;
                    pack_data_r <= 32'd0;
                    pack_sel_r  <= 4'd0;
                end else begin
                    idx_r       <= idx_r + 2'd1;
                    pack_data_r <= merged_data_s;
                    pack_sel_r  <= merged_sel_s;
                end
            end
            if (wbuf_load_s) begin
                wbuf_full_r <= 1'b1;
                wbuf_data_r <= merged_data_s;
                wbuf_sel_r  <= merged_sel_s;
                wbuf_last_r <= s2_last_r;
            end else if (retire_s) begin
                wbuf_full_r <= 1'b0;
            end
        end
    end

    assign cfu_ram_adr      = ptr_r;
    assign cfu_ram_dat_mosi = wbuf_data_r;
    assign cfu_ram_sel      = wbuf_sel_r;
    assign cfu_ram_cyc      = cyc_r;
    assign cfu_ram_stb      = cyc_r;
    assign cfu_ram_we       = cyc_r;
    assign cfu_ram_cti      = 3'd0;
    assign cfu_ram_bte      = 2'd0;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err_flag         = err_flag_r;
    assign words_written    = words_r;

endmodule

// File: tb/tb_cnn_requant_writer.sv
// Randomized self-checking bench for cnn_requant_writer with an arithmetic
// reference model and a Wishbone slave that records every write.
module tb_cnn_requant_writer;
    localparam int ADDR_W = 30;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] cfg_base_adr = '0;
    logic [31:0]       cfg_bias = 32'd0, cfg_mult = 32'd0;
    logic [4:0]        cfg_shift = 5'd0;
    logic [8:0]        cfg_out_offset = 9'd0;
    logic              acc_valid = 1'b0, acc_ready, acc_last = 1'b0;
    logic [31:0]       acc_data = 32'd0;
    logic [ADDR_W-1:0] cfu_ram_adr;
    logic [31:0]       cfu_ram_dat_mosi, cfu_ram_dat_miso = 32'd0;
    logic [3:0]        cfu_ram_sel;
    logic              cfu_ram_cyc, cfu_ram_stb, cfu_ram_we;
    logic [2:0]        cfu_ram_cti;
    logic [1:0]        cfu_ram_bte;
    logic              cfu_ram_ack = 1'b0, cfu_ram_err = 1'b0;
    logic              busy, done, err_flag;
    logic [CNT_W-1:0]  words_written;

    always #5 clk = ~clk;

    cnn_requant_writer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base_adr(cfg_base_adr),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_out_offset(cfg_out_offset), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .acc_last(acc_last), .cfu_ram_adr(cfu_ram_adr),
        .cfu_ram_dat_mosi(cfu_ram_dat_mosi), .cfu_ram_sel(cfu_ram_sel),
        .cfu_ram_cyc(cfu_ram_cyc), .cfu_ram_stb(cfu_ram_stb), .cfu_ram_we(cfu_ram_we),
        .cfu_ram_cti(cfu_ram_cti), .cfu_ram_bte(cfu_ram_bte),
        .cfu_ram_dat_miso(cfu_ram_dat_miso), .cfu_ram_ack(cfu_ram_ack),
        .cfu_ram_err(cfu_ram_err), .busy(busy), .done(done), .err_flag(err_flag),
        .words_written(words_written)
    );

    typedef struct {
        logic [ADDR_W-1:0] adr;
        logic [31:0]       dat;
        logic [3:0]        sel;
    } wr_t;

    int  total = 0;
    int  bad = 0;
    wr_t got_q[$];
    int  acc_q[$];
    int  ack_delay = 0;
    int  err_mask = 0;
    int  both_mask = 0;
    int  slave_idx = 0;
    int  done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int acc, input int bias, input int mult,
                                            input int sh, input int off);
        int     s1;
        longint p;
        int     h;
        int     r;
        longint o;
        s1 = acc + bias;
        p  = longint'(s1) * longint'(mult);
        h  = int'((p + (longint'(1) <<< 30)) >>> 31);
        if (sh > 0) r = (h + (1 << (sh - 1))) >>> sh;
        else        r = h;
        o = longint'(r) + longint'(off);
        if (o > 127) o = 127;
        else if (o < -128) o = -128;
        return o[7:0];
    endfunction

    // Wishbone slave: records each write, checks request stability, answers after ack_delay.
    initial begin
        wr_t w;
        bit  aborted;
        forever begin
            @(negedge clk);
            if (cfu_ram_cyc && cfu_ram_stb && cfu_ram_we) begin
                w.adr = cfu_ram_adr;
                w.dat = cfu_ram_dat_mosi;
                w.sel = cfu_ram_sel;
                aborted = 1'b0;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    if (!cfu_ram_cyc) begin
                        aborted = 1'b1;
                        break;
                    end
                    check("hold_ctl", 64'({cfu_ram_stb, cfu_ram_we}), 64'd3);
                    check("hold_adr", 64'(cfu_ram_adr), 64'(w.adr));
                    check("hold_dat", 64'(cfu_ram_dat_mosi), 64'(w.dat));
                    check("hold_sel", 64'(cfu_ram_sel), 64'(w.sel));
                end
                if (!aborted) begin
                    got_q.push_back(w);
                    cfu_ram_err = err_mask[slave_idx] | both_mask[slave_idx];
                    cfu_ram_ack = ~err_mask[slave_idx];
                    slave_idx++;
                    @(negedge clk);
                    cfu_ram_ack = 1'b0;
                    cfu_ram_err = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    end

    task automatic set_cfg(input logic [ADDR_W-1:0] base, input int bias, input int mult,
                           input int sh, input int off);
        cfg_base_adr   = base;
        cfg_bias       = bias;
        cfg_mult       = mult;
        cfg_shift      = sh[4:0];
        cfg_out_offset = off[8:0];
    endtask

    task automatic drive_accs(input int gap, input bit poke_start, output int stalls);
        int waited;
        stalls = 0;
        for (int i = 0; i < acc_q.size(); i++) begin
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                acc_valid = 1'b0;
                @(negedge clk);
            end
            acc_valid = 1'b1;
            acc_data  = acc_q[i];
            acc_last  = (i == acc_q.size() - 1);
            if (poke_start && i == 1) start = 1'b1;
            waited = 0;
            while (!acc_ready && waited < 300) begin
                @(negedge clk);
                start = 1'b0;
                waited++;
                stalls++;
            end
            check("acc_timeout", 64'(waited >= 300), 64'd0);
            @(negedge clk);
            start = 1'b0;
        end
        acc_valid = 1'b0;
        acc_last  = 1'b0;
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] base, input int bias, input int mult,
                           input int sh, input int off, input int delay, input int gap,
                           input bit poke_start);
        wr_t        exp_q[$];
        wr_t        e;
        logic [31:0] word;
        logic [3:0]  sel;
        int         lane;
        int         stalls;
        int         waited;
        int         d0;
        bit         exp_err;
        set_cfg(base, bias, mult, sh, off);
        ack_delay = delay;
        got_q.delete();
        slave_idx = 0;
        word = 32'd0; sel = 4'd0; lane = 0; exp_err = 1'b0;
        for (int i = 0; i < acc_q.size(); i++) begin
            word[8*lane +: 8] = ref_byte(acc_q[i], bias, mult, sh, off);
            sel[lane] = 1'b1;
            if (lane == 3 || i == acc_q.size() - 1) begin
                e.adr = base + ADDR_W'(exp_q.size());
                e.dat = word;
                e.sel = sel;
                if (err_mask[exp_q.size()] || both_mask[exp_q.size()]) exp_err = 1'b1;
                exp_q.push_back(e);
                word = 32'd0; sel = 4'd0; lane = 0;
            end else begin
                lane++;
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_words", 64'(words_written), 64'd0);
        check("start_errflag", 64'(err_flag), 64'd0);
        d0 = done_cnt;
        drive_accs(gap, poke_start, stalls);
        check("ready_after_last", 64'(acc_ready), 64'd0);
        if (delay >= 8 && acc_q.size() >= 8) check("backpressure_stall", 64'(stalls > 0), 64'd1);
        waited = 0;
        while (!done && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("done_timeout", 64'(waited >= 2000), 64'd0);
        check("busy_with_done", 64'(busy), 64'd1);
        check("words_written", 64'(words_written), 64'(exp_q.size()));
        check("err_flag", 64'(err_flag), 64'(exp_err));
        @(negedge clk);
        check("done_pulse_width", 64'(done), 64'd0);
        check("busy_fall", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            check("wr_adr", 64'(got_q[k].adr), 64'(exp_q[k].adr));
            check("wr_dat", 64'(got_q[k].dat), 64'(exp_q[k].dat));
            check("wr_sel", 64'(got_q[k].sel), 64'(exp_q[k].sel));
        end
    endtask

    initial begin
        int stalls;
        int waited;
        int n;
        // Reset state
        #12;
        check("rst_cyc", 64'({cfu_ram_cyc, cfu_ram_stb, cfu_ram_we}), 64'd0);
        check("rst_status", 64'({busy, done, err_flag, acc_ready}), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        check("rst_bus", 64'({cfu_ram_adr, cfu_ram_sel}), 64'd0);
        check("rst_dat", 64'(cfu_ram_dat_mosi), 64'd0);
        check("const_cti_bte", 64'({cfu_ram_cti, cfu_ram_bte}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        acc_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_not_ready", 64'(acc_ready), 64'd0);
        end
        acc_valid = 1'b0;

        // Basic packing
        acc_q = '{2, 4, -6, 1000};
        run_job(30'h100, 0, 32'h40000000, 0, 0, 0, 0, 1'b0);
        if (got_q.size() > 0) check("basic_dat", 64'(got_q[0].dat), 64'h7FFD0201);

        // Rounding
        acc_q = '{6};
        run_job(30'h40, 0, 32'h7FFFFFFF, 2, -128, 1, 0, 1'b0);
        if (got_q.size() > 0) check("round_dat", 64'(got_q[0].dat), 64'h00000082);

        // Partial final word, plus start while busy being ignored
        acc_q = '{10, -20, 30, -40, 50};
        run_job(30'h100, 0, 32'h40000000, 0, 0, 0, 0, 1'b1);
        if (got_q.size() > 1) check("partial_sel", 64'(got_q[1].sel), 64'h1);

        // Back-pressure with slow ack
        acc_q = {};
        for (int i = 0; i < 12; i++) acc_q.push_back(i * 37 - 200);
        run_job(30'h200, 5, 32'h20000000, 1, 3, 10, 0, 1'b0);

        // Bus error on first of two words, then ack+err together
        acc_q = '{1, 2, 3, 4, 5, 6};
        err_mask = 1;
        run_job(30'h300, 0, 32'h40000000, 0, 0, 0, 0, 1'b0);
        err_mask = 0;
        both_mask = 2;
        run_job(30'h310, 0, 32'h40000000, 0, 0, 2, 0, 1'b0);
        both_mask = 0;

        // Pointer wrap at the top of the address space
        acc_q = '{100, 200, 300, 400, 500};
        run_job(30'h3FFFFFFF, -50, 32'h10000000, 3, -7, 0, 20, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(1, 13);
            acc_q = {};
            for (int i = 0; i < n; i++)
                acc_q.push_back($urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000);
            err_mask = int'($urandom_range(0, 15)) & int'($urandom_range(0, 15));
            run_job(ADDR_W'($urandom), $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100,
                    $urandom_range(0, 1) ? int'($urandom_range(0, 32'h7FFFFFFF)) : int'($urandom_range(0, 32'h00FFFFFF)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 511)) - 256,
                    int'($urandom_range(0, 6)), 30, 1'b0);
        end
        err_mask = 0;

        // Reset asserted mid-write
        acc_q = '{1, 2, 3, 4};
        set_cfg(30'h500, 0, 32'h40000000, 0, 0);
        ack_delay = 40;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_accs(0, 1'b0, stalls);
        waited = 0;
        while (!cfu_ram_cyc && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_cyc_seen", 64'(cfu_ram_cyc), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_ctl", 64'({cfu_ram_cyc, cfu_ram_stb, cfu_ram_we, busy}), 64'd0);
        check("rst_mid_words", 64'(words_written), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        acc_q = '{-3, 9, 27};
        run_job(30'h2A0, 7, 32'h55555555, 4, 11, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
